// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch front end with PC, imem req/ack and a fetch queue toward decode.
// Optional FETCH_STATS_EN adds stat_fetched / stat_stall counters.
module fetch_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] initial_address,
  input  logic            tr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_stall,
`endif
  output logic [XLEN-1:0] if_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, DROP} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] pc, drop_addr;
  logic held, flush, push, pop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc [DEPTH];
  assign flush = redirect_valid && state != BOOT;
  // held keeps an unacknowledged request alive even if tr drops
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    imem_addr = pc;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        imem_req = held || (tr && count != FULL);
        state_nx = (flush && imem_req && !imem_ack) ? DROP : RUN;
      end
      DROP: begin
        imem_req = 1'b1;
        imem_addr = drop_addr;
        state_nx = imem_ack ? RUN : DROP;
      end
      default: state_nx = BOOT;
    endcase
  end
  assign push = state == RUN && imem_req && imem_ack && !flush;
  assign pop = if_valid && id_ready && !flush;
  assign if_valid = count != '0;
  assign if_instr = if_valid ? q_instr[rd_ptr] : '0;
  assign if_pc = if_valid ? q_pc[rd_ptr] : '0;
  assign if_pc_plus4 = if_pc + XLEN'(4);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= BOOT;
      pc <= '0;
      drop_addr <= '0;
      held <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      held <= state == RUN && imem_req && !imem_ack && !flush;
      if (state == RUN && flush && imem_req && !imem_ack) drop_addr <= pc;
      if (state == BOOT) pc <= initial_address & ~XLEN'(3);
      else if (flush) pc <= redirect_pc & ~XLEN'(3);
      else if (push) pc <= pc + XLEN'(4);
      if (flush) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr] <= pc;
    end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_fetched <= '0;
      stat_stall <= '0;
    end else begin
      if (push) stat_fetched <= stat_fetched + 32'd1;
      if (state == RUN && tr && (imem_req ? !imem_ack : count == FULL)) stat_stall <= stat_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard queue of expected fetch PCs checked by a decode-side monitor.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset, tr, imem_req, imem_ack, redirect_valid, id_ready, if_valid;
  logic [31:0] initial_address, imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, if_pc_plus4;
  int vectors = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction
  assign imem_rdata = mem(imem_addr);
  fetch_stage dut (
    .clk(clk), .reset(reset), .initial_address(initial_address), .tr(tr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fetch_cycle(input bit a, input bit exp_req, input logic [31:0] exp_addr, input bit keep);
    imem_ack = a;
    #3;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    if (keep && a && exp_req) exp_q.push_back(exp_addr);
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_instr"}, if_instr, 32'd0);
    check({tag, "_pc"}, if_pc, 32'd0);
    check({tag, "_pc4"}, if_pc_plus4, 32'd4);
  endtask
  always @(negedge clk)
    if (reset && if_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h expected none", if_pc);
      end else begin
        logic [31:0] p;
        p = exp_q.pop_front();
        check("if_pc", if_pc, p);
        check("if_instr", if_instr, mem(p));
        check("if_pc_plus4", if_pc_plus4, p + 32'd4);
      end
    end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b0; tr = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; initial_address = 32'h100;
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b1; tr = 1'b1; id_ready = 1'b1;
    fetch_cycle(1, 0, 32'h0, 0);
    fetch_cycle(1, 1, 32'h100, 1);
    check("latency_valid", 32'(if_valid), 32'd1);
    check("latency_pc", if_pc, 32'h100);
    fetch_cycle(1, 1, 32'h104, 1);
    fetch_cycle(1, 1, 32'h108, 1);
    tr = 1'b0;
    fetch_cycle(0, 0, 32'h10C, 0);
    id_ready = 1'b0; tr = 1'b1;
    fetch_cycle(1, 1, 32'h10C, 1);
    fetch_cycle(1, 1, 32'h110, 1);
    fetch_cycle(1, 0, 32'h114, 0);
    fetch_cycle(1, 0, 32'h114, 0);
    id_ready = 1'b1;
    fetch_cycle(1, 0, 32'h114, 0);
    fetch_cycle(1, 1, 32'h114, 1);
    tr = 1'b0;
    fetch_cycle(0, 0, 32'h118, 0);
    fetch_cycle(0, 0, 32'h118, 0);
    tr = 1'b1;
    fetch_cycle(0, 1, 32'h118, 0);
    tr = 1'b0;
    fetch_cycle(0, 1, 32'h118, 0);
    tr = 1'b1;
    fetch_cycle(0, 1, 32'h118, 0);
    tr = 1'b0;
    fetch_cycle(1, 1, 32'h118, 1);
    fetch_cycle(0, 0, 32'h11C, 0);
    tr = 1'b1; id_ready = 1'b0;
    fetch_cycle(1, 1, 32'h11C, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    fetch_cycle(0, 1, 32'h120, 0);
    redirect_valid = 1'b0;
    check("flush_valid", 32'(if_valid), 32'd0);
    fetch_cycle(0, 1, 32'h120, 0);
    fetch_cycle(1, 1, 32'h120, 0);
    check("drop_valid", 32'(if_valid), 32'd0);
    id_ready = 1'b1;
    fetch_cycle(1, 1, 32'h200, 1);
    fetch_cycle(1, 1, 32'h204, 1);
    tr = 1'b0;
    fetch_cycle(0, 0, 32'h208, 0);
    tr = 1'b1; id_ready = 1'b0;
    fetch_cycle(1, 1, 32'h208, 0);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    fetch_cycle(1, 1, 32'h20C, 0);
    redirect_valid = 1'b0;
    check("redir_pop_valid", 32'(if_valid), 32'd0);
    fetch_cycle(1, 1, 32'h40, 1);
    tr = 1'b0;
    fetch_cycle(0, 0, 32'h44, 0);
    tr = 1'b1; id_ready = 1'b0;
    fetch_cycle(1, 1, 32'h44, 0);
    initial_address = 32'h302;
    #1 reset = 1'b0;
    #1 check_reset_outputs("async");
    #3 reset = 1'b1;
    id_ready = 1'b1;
    @(posedge clk);
    #1;
    fetch_cycle(1, 1, 32'h300, 1);
    fetch_cycle(1, 1, 32'h304, 1);
    tr = 1'b0;
    fetch_cycle(0, 0, 32'h308, 0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
